// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART byte path: default byte/opcode widths and
// the controller state encoding. Also reused by the receiver and transmitter
// benches.
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  // States in which a new frame cannot be accepted.
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/uart_alu_intf.sv
// ----------------------------------------------------------------------------
// uart_alu_intf
// Collects operand A, operand B and opcode bytes from the UART receiver,
// presents them to an external combinational ALU, captures the result and
// hands it to the UART transmitter with a one-cycle start pulse. The next
// frame is accepted only after the transmitter reports completion.
//
// Ports:
//   i_clk, i_reset      clock; asynchronous active-high reset
//   i_rx_data/_done_tick received byte and its one-cycle valid pulse
//   i_tx_done_tick      transmitter finished the current byte
//   i_alu_result        combinational ALU output
//   o_alu_a/_b/_op      registered ALU operands and opcode
//   o_tx_data           registered result byte for the transmitter
//   o_tx_start          one-cycle transmit request
//   o_busy              high while a frame is being executed/sent
//   o_overrun           sticky: a byte arrived while busy and was dropped
// ----------------------------------------------------------------------------
module uart_alu_intf
  import uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done_tick,
  input  logic               i_tx_done_tick,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_overrun
);

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_ld_a;
  logic                 w_ld_b;
  logic                 w_ld_op;
  logic                 w_ld_tx;

  logic [NB_DATA-1:0]   r_alu_a;
  logic [NB_DATA-1:0]   r_alu_b;
  logic [NB_OP-1:0]     r_alu_op;
  logic [NB_DATA-1:0]   r_tx_data;
  logic                 r_tx_start;
  logic                 r_busy;
  logic                 r_overrun;

  // Next-state and load-enable decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_ld_a       = 1'b0;
    w_ld_b       = 1'b0;
    w_ld_op      = 1'b0;
    w_ld_tx      = 1'b0;

    unique case (r_state)
      ST_WAIT_A: if (i_rx_done_tick) begin
        w_ld_a       = 1'b1;
        w_next_state = ST_WAIT_B;
      end
      ST_WAIT_B: if (i_rx_done_tick) begin
        w_ld_b       = 1'b1;
        w_next_state = ST_WAIT_OP;
      end
      ST_WAIT_OP: if (i_rx_done_tick) begin
        w_ld_op      = 1'b1;
        w_next_state = ST_EXEC;
      end
      // One settling cycle for the external ALU, then capture its result.
      ST_EXEC: begin
        w_ld_tx      = 1'b1;
        w_next_state = ST_SEND;
      end
      ST_SEND:    w_next_state = ST_WAIT_TX;
      // A byte arriving together with the done tick is still dropped.
      ST_WAIT_TX: if (i_tx_done_tick) w_next_state = ST_WAIT_A;
      default:    w_next_state = ST_WAIT_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_WAIT_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_ld_a)  r_alu_a   <= i_rx_data;
      if (w_ld_b)  r_alu_b   <= i_rx_data;
      if (w_ld_op) r_alu_op  <= i_rx_data[NB_OP-1:0];
      if (w_ld_tx) r_tx_data <= i_alu_result;
      // Registered one cycle behind SEND so the pulse lands one cycle after
      // o_tx_data is already stable.
      r_tx_start <= (r_state == ST_SEND);
      r_busy     <= is_busy_state(w_next_state);
      if (i_rx_done_tick && is_busy_state(r_state)) r_overrun <= 1'b1;
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_busy     = r_busy;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_uart_alu_intf.sv
// ----------------------------------------------------------------------------
// tb_uart_alu_intf
// Directed plus randomized bench for uart_alu_intf. The external ALU is
// modelled as A+B; expected values come from the stimulus bytes themselves.
// ----------------------------------------------------------------------------
module tb_uart_alu_intf;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NB_DATA-1:0] rx_data = '0;
  logic               rx_tick = 1'b0;
  logic               tx_tick = 1'b0;
  logic [NB_DATA-1:0] alu_result;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic               busy;
  logic               overrun;

  uart_alu_intf #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_rx_data      (rx_data),
    .i_rx_done_tick (rx_tick),
    .i_tx_done_tick (tx_tick),
    .i_alu_result   (alu_result),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .o_alu_op       (alu_op),
    .o_tx_data      (tx_data),
    .o_tx_start     (tx_start),
    .o_busy         (busy),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Bench ALU: plain addition, wrapping at 8 bits.
  assign alu_result = alu_a + alu_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // number of rising edges so far
  int starts   = 0;   // total o_tx_start pulses seen
  int start_cyc = -1; // edge index after which the last pulse was high
  int tick_cyc  = 0;  // edge index that sampled the last rx tick

  always @(posedge clk) cyc <= cyc + 1;

  // Reads the pre-edge value: a pulse that was high after edge k is logged as k.
  always @(posedge clk) begin
    if (tx_start === 1'b1) begin
      starts    = starts + 1;
      start_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    rx_data = d;
    rx_tick = 1'b1;
    @(negedge clk);
    rx_tick  = 1'b0;
    tick_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},       32'(alu_a),    32'h0);
    check({tag, "_b"},       32'(alu_b),    32'h0);
    check({tag, "_op"},      32'(alu_op),   32'h0);
    check({tag, "_tx_data"}, 32'(tx_data),  32'h0);
    check({tag, "_start"},   32'(tx_start), 32'h0);
    check({tag, "_busy"},    32'(busy),     32'h0);
    check({tag, "_overrun"}, 32'(overrun),  32'h0);
  endtask

  // Sends one full frame and checks operands, result and start-pulse timing.
  // Leaves the DUT waiting for the transmitter.
  task automatic do_frame(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] opb, input bit stray_tx);
    int s0;
    logic [7:0] exp_sum;
    s0      = starts;
    exp_sum = a + b;
    send_byte(a);
    idle(int'($urandom_range(0, 3)));
    // A transmitter tick outside WAIT_TX must have no effect.
    if (stray_tx) begin
      @(negedge clk); tx_tick = 1'b1;
      @(negedge clk); tx_tick = 1'b0;
    end
    send_byte(b);
    idle(int'($urandom_range(0, 3)));
    send_byte(opb);
    check("frame_a",    32'(alu_a),  32'(a));
    check("frame_b",    32'(alu_b),  32'(b));
    check("frame_op",   32'(alu_op), 32'(opb % 64));
    check("frame_busy", 32'(busy),   32'h1);
    for (int i = 0; i < 10; i++) begin
      if (starts != s0) break;
      @(negedge clk);
    end
    check("start_count",   32'(starts),    32'(s0 + 1));
    check("start_latency", 32'(start_cyc), 32'(tick_cyc + 2));
    check("tx_data",       32'(tx_data),   32'(exp_sum));
    idle(3);
    check("single_start",  32'(starts),    32'(s0 + 1));
    check("busy_wait_tx",  32'(busy),      32'h1);
  endtask

  task automatic finish_tx();
    @(negedge clk); tx_tick = 1'b1;
    @(negedge clk); tx_tick = 1'b0;
    check("busy_after_tx", 32'(busy), 32'h0);
  endtask

  initial begin
    logic [7:0] ra, rb, rop;
    logic [7:0] keep_a;
    int s0;

    // Reset state.
    #1;
    check_all_zero("reset");
    idle(2);
    rst = 1'b0;
    idle(2);
    check_all_zero("post_reset");

    // Basic frame: 5 + 3.
    do_frame(8'h05, 8'h03, 8'h20, 1'b0);
    finish_tx();

    // Opcode upper bits stripped.
    do_frame(8'h11, 8'h22, 8'hE2, 1'b0);
    check("op_strip", 32'(alu_op), 32'h22);
    finish_tx();

    // Byte arriving in WAIT_TX is dropped and flags overrun.
    do_frame(8'h40, 8'h02, 8'h01, 1'b0);
    send_byte(8'h7F);
    check("ovr_flag",  32'(overrun), 32'h1);
    check("ovr_a",     32'(alu_a),   32'h40);
    check("ovr_b",     32'(alu_b),   32'h02);
    check("ovr_busy",  32'(busy),    32'h1);
    finish_tx();
    do_frame(8'h0A, 8'h0B, 8'h03, 1'b0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    finish_tx();

    // Reset mid-frame: everything cleared, no start pulse.
    s0 = starts;
    send_byte(8'h33);
    send_byte(8'h44);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    check("mid_reset_no_start", 32'(starts), 32'(s0));
    do_frame(8'h10, 8'h01, 8'h20, 1'b0);
    check("mid_reset_result", 32'(tx_data), 32'h11);
    finish_tx();

    // Transmitter completion withheld for 1000 cycles.
    do_frame(8'h80, 8'h90, 8'h05, 1'b0);
    s0 = starts;
    idle(1000);
    check("hold_busy",   32'(busy),   32'h1);
    check("hold_starts", 32'(starts), 32'(s0));
    finish_tx();

    // Byte and transmitter tick in the same WAIT_TX cycle.
    do_frame(8'h21, 8'h12, 8'h07, 1'b0);
    @(negedge clk);
    rx_data = 8'h99; rx_tick = 1'b1; tx_tick = 1'b1;
    @(negedge clk);
    rx_tick = 1'b0; tx_tick = 1'b0;
    check("coinc_busy",    32'(busy),    32'h0);
    check("coinc_overrun", 32'(overrun), 32'h1);
    check("coinc_a",       32'(alu_a),   32'h21);
    // The very next byte must become operand A.
    do_frame(8'h01, 8'hFF, 8'h3F, 1'b0);
    finish_tx();

    // Randomized frames, with occasional stray transmitter ticks.
    for (int n = 0; n < 20; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 8'($urandom);
      do_frame(ra, rb, rop, ($urandom_range(0, 3) == 0));
      keep_a = ra;
      if ($urandom_range(0, 4) == 0) begin
        send_byte(8'($urandom));
        check("rand_drop_a", 32'(alu_a), 32'(keep_a));
      end
      idle(int'($urandom_range(0, 5)));
      finish_tx();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
